// File: rtl/mem_arbiter_if.sv
// Requester and RAM side signals of the memory arbiter.
// slave: the arbiter itself; master: the requesters and the RAM.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ramready;

  // Handshake: a requester raises xREN/xWEN and holds it, with address and
  // data stable, while xwait is high; the cycle xwait is low with the request
  // still asserted is the completion cycle and xload is valid only then.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data path has priority, a starvation counter forces fetch.
// Optional MEM_ARB_PERF_EN adds icount/dcount/stallcnt performance counters.
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  mem_arbiter_if.slave bus,
  output logic [1:0]  o_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_I = 2'd1,
    SERV_D = 2'd2
  } state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_starve;
  logic          r_ram_ren;
  logic          r_ram_wen;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_store;
  logic          w_dreq;
  logic          w_decide;
  logic          w_force_i;
  logic          w_i_done;
  logic          w_d_done;
  logic          w_iwait;
  logic          w_dwait;

  assign w_dreq    = bus.dREN | bus.dWEN;
  // ramready only counts while serving; in IDLE a decision is taken every cycle.
  assign w_decide  = (r_state == IDLE) || bus.ramready;
  assign w_force_i = bus.iREN && (r_starve == CW'(STARVE_LIMIT));
  assign w_i_done  = (r_state == SERV_I) && bus.ramready;
  assign w_d_done  = (r_state == SERV_D) && bus.ramready;
  assign w_iwait   = bus.iREN & ~w_i_done;
  assign w_dwait   = w_dreq & ~w_d_done;

  always_comb begin
    w_next = r_state;
    if (w_decide) begin
      if (w_dreq && !w_force_i) w_next = SERV_D;
      else if (bus.iREN)        w_next = SERV_I;
      else                      w_next = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // RAM-side registers latch the winner at the decision and hold until ramready.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_store <= '0;
    end else if (w_decide) begin
      case (w_next)
        SERV_D: begin
          r_ram_ren   <= bus.dREN;
          r_ram_wen   <= bus.dWEN;
          r_ram_addr  <= bus.daddr;
          r_ram_store <= bus.dstore;
        end
        SERV_I: begin
          r_ram_ren  <= 1'b1;
          r_ram_wen  <= 1'b0;
          r_ram_addr <= bus.iaddr;
        end
        default: begin
          r_ram_ren <= 1'b0;
          r_ram_wen <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                 r_starve <= '0;
    else if (!bus.iREN)                        r_starve <= '0;
    else if (w_decide && w_next == SERV_I)     r_starve <= '0;
    else if (w_decide && w_next == SERV_D &&
             r_starve != CW'(STARVE_LIMIT))    r_starve <= r_starve + CW'(1);
  end

  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = r_ram_ren;
  assign bus.ramWEN   = r_ram_wen;
  assign bus.ramaddr  = r_ram_addr;
  assign bus.ramstore = r_ram_store;
  assign o_state      = r_state;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount   <= '0;
      dcount   <= '0;
      stallcnt <= '0;
    end else begin
      if (w_i_done)          icount   <= icount + 32'd1;
      if (w_d_done)          dcount   <= dcount + 32'd1;
      if (w_iwait | w_dwait) stallcnt <= stallcnt + 32'd1;
    end
  end
`endif

endmodule
